// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, ALU input-control codes, FSM states and the command
// bundle shared by the ALU command-issue front end.
package alu_pkg;

  localparam logic [6:0] OP_ADD = 7'b1000000;
  localparam logic [6:0] OP_SUB = 7'b0100000;
  localparam logic [6:0] OP_AND = 7'b0010000;
  localparam logic [6:0] OP_OR  = 7'b0001000;
  localparam logic [6:0] OP_XOR = 7'b0000100;
  localparam logic [6:0] OP_NOT = 7'b0000010;
  localparam logic [6:0] OP_SHL = 7'b0000001;

  localparam logic [2:0] INSEL_PERSIST = 3'b100;
  localparam logic [2:0] INSEL_LOAD    = 3'b010;
  localparam logic [2:0] INSEL_RESET   = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] num1;
    logic [7:0] num2;
    logic [6:0] op;
  } cmd_t;

  function automatic logic op_legal(input logic [6:0] op);
    return $onehot(op);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: power-of-two synchronous FIFO of ALU commands with a
// first-word-fall-through head output.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  cmd_t i_data,
  input  logic i_pop,
  output logic o_full,
  output logic o_empty,
  output cmd_t o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // pointers wrap for free because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues commands and sequences load/wait/capture into ALU main.
// Define ALU_ISSUE_ERRCHK_EN to drop (and flag) commands whose op is not one-hot.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_num1,
  input  logic [7:0] cmd_num2,
  input  logic [6:0] cmd_op,
  output logic       alu_on,
  output logic [2:0] alu_in_sel,
  output logic [7:0] alu_num1,
  output logic [7:0] alu_num2,
  output logic [6:0] alu_out_sel,
  input  logic [7:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [6:0] res_op,
  output logic       err_op,
  output logic       busy
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  cmd_t          w_cmd;
  cmd_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_legal;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_on;
  logic          r_err;
  logic          r_res_valid;
  logic [2:0]    r_in_sel;
  logic [7:0]    r_num1;
  logic [7:0]    r_num2;
  logic [6:0]    r_op;
  logic [7:0]    r_res_data;
  logic [6:0]    r_res_op;

  assign w_cmd     = {cmd_num1, cmd_num2, cmd_op};
  assign cmd_ready = rst && !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;

`ifdef ALU_ISSUE_ERRCHK_EN
  assign w_legal = op_legal(w_head.op);
`else
  assign w_legal = 1'b1;
`endif

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_cmd),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_on        <= 1'b0;
      r_err       <= 1'b0;
      r_in_sel    <= INSEL_RESET;
      r_num1      <= '0;
      r_num2      <= '0;
      r_op        <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_op    <= '0;
    end else begin
      r_on  <= 1'b1;
      r_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_in_sel <= INSEL_PERSIST;
          if (!w_empty) begin
            if (w_legal) begin
              r_state  <= ST_LOAD;
              r_in_sel <= INSEL_LOAD;
              r_num1   <= w_head.num1;
              r_num2   <= w_head.num2;
              r_op     <= w_head.op;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          r_in_sel <= INSEL_PERSIST;
          r_cnt    <= CW'(ALU_LAT - 1);
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_res_data  <= alu_out;
            r_res_op    <= r_op;
            r_res_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign alu_on      = r_on;
  assign alu_in_sel  = r_in_sel;
  assign alu_num1    = r_num1;
  assign alu_num2    = r_num2;
  assign alu_out_sel = r_op;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_op      = r_res_op;
  assign err_op      = r_err;
  assign busy        = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: scoreboard bench with a behavioural ALU model;
// one instance at ALU_LAT=2 and one at ALU_LAT=1 for the streaming case.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int LAT = 2;
`ifdef ALU_ISSUE_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic [6:0] op;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_num1 = '0;
  logic [7:0] cmd_num2 = '0;
  logic [6:0] cmd_op = '0;
  logic       alu_on;
  logic [2:0] alu_in_sel;
  logic [7:0] alu_num1, alu_num2, alu_out;
  logic [6:0] alu_out_sel;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic [6:0] res_op;
  logic       err_op, busy;

  logic       c1_valid = 1'b0;
  logic       c1_ready;
  logic       alu1_on;
  logic [2:0] alu1_in_sel;
  logic [7:0] alu1_num1, alu1_num2, alu1_out;
  logic [6:0] alu1_out_sel;
  logic       res1_valid;
  logic       res1_ready = 1'b1;
  logic [7:0] res1_data;
  logic [6:0] res1_op;
  logic       err1_op, busy1;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_num1(cmd_num1), .cmd_num2(cmd_num2), .cmd_op(cmd_op),
    .alu_on(alu_on), .alu_in_sel(alu_in_sel),
    .alu_num1(alu_num1), .alu_num2(alu_num2),
    .alu_out_sel(alu_out_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op),
    .err_op(err_op), .busy(busy)
  );

  alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_num1(cmd_num1), .cmd_num2(cmd_num2), .cmd_op(cmd_op),
    .alu_on(alu1_on), .alu_in_sel(alu1_in_sel),
    .alu_num1(alu1_num1), .alu_num2(alu1_num2),
    .alu_out_sel(alu1_out_sel), .alu_out(alu1_out),
    .res_valid(res1_valid), .res_ready(res1_ready),
    .res_data(res1_data), .res_op(res1_op),
    .err_op(err1_op), .busy(busy1)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [6:0] op);
    case (op)
      7'b1000000: return a + b;
      7'b0100000: return a - b;
      7'b0010000: return a & b;
      7'b0001000: return a | b;
      7'b0000100: return a ^ b;
      7'b0000010: return ~a;
      7'b0000001: return {a[6:0], 1'b0};
      default:    return a ^ b ^ 8'h5A;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] op);
    bit en;
    en = ERRCHK;
    return !en || $onehot(op);
  endfunction

  // behavioural ALU: latches operands on a load cycle, result combinational
  logic [7:0] m0_a, m0_b, m1_a, m1_b;
  logic [6:0] m0_op, m1_op;
  always @(posedge clk) begin
    if (alu_on && alu_in_sel == 3'b010) begin
      m0_a <= alu_num1; m0_b <= alu_num2; m0_op <= alu_out_sel;
    end
    if (alu1_on && alu1_in_sel == 3'b010) begin
      m1_a <= alu1_num1; m1_b <= alu1_num2; m1_op <= alu1_out_sel;
    end
  end
  assign alu_out  = alu_f(m0_a, m0_b, m0_op);
  assign alu1_out = alu_f(m1_a, m1_b, m1_op);

  always @(negedge clk) begin
    if (rst && cmd_valid && cmd_ready && legal(cmd_op))
      sb.push_back('{alu_f(cmd_num1, cmd_num2, cmd_op), cmd_op});
    if (rst && c1_valid && c1_ready && legal(cmd_op))
      q1.push_back('{alu_f(cmd_num1, cmd_num2, cmd_op), cmd_op});
  end

  task automatic push0(input logic [7:0] a, input logic [7:0] b,
                       input logic [6:0] op, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    cmd_num1 = a; cmd_num2 = b; cmd_op = op; cmd_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1; n++;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic push1(input logic [7:0] a, input logic [7:0] b,
                       input logic [6:0] op, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    cmd_num1 = a; cmd_num2 = b; cmd_op = op; c1_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk); ok = c1_ready;
      @(posedge clk); #1; n++;
    end
    c1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cmd_ready, alu_on, res_valid, err_op, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=00000",
               {cmd_ready, alu_on, res_valid, err_op, busy});
    end
    total++;
    if (alu_in_sel !== 3'b001) begin
      bad++; $display("FAIL reset_in_sel got=%b exp=001", alu_in_sel);
    end
    total++;
    if ({alu_num1, alu_num2, alu_out_sel} !== 23'h0) begin
      bad++; $display("FAIL reset_alu_bus got=%h exp=0",
                      {alu_num1, alu_num2, alu_out_sel});
    end
    total++;
    if ({res_data, res_op} !== 15'h0) begin
      bad++; $display("FAIL reset_res got=%h exp=0", {res_data, res_op});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({alu_on, cmd_ready, busy} !== 3'b110) begin
      bad++; $display("FAIL post_reset got=%b exp=110",
                      {alu_on, cmd_ready, busy});
    end
    total++;
    if (alu_in_sel !== 3'b100) begin
      bad++; $display("FAIL post_reset_in_sel got=%b exp=100", alu_in_sel);
    end
  endtask

  task automatic test_single();
    bit   ok;
    int   n0, loads, load_at, rise_at, got;
    exp_t e;
    res_ready = 1'b1;
    push0(8'h02, 8'h04, OP_ADD, ok);
    n0 = cyc;
    total++;
    if (!ok) begin bad++; $display("FAIL single_push got=0 exp=1"); end
    loads = 0; load_at = -1; rise_at = -1; got = 0;
    for (int k = 0; k < 20 && got < 1; k++) begin
      @(negedge clk);
      if (alu_in_sel == 3'b010) begin
        loads++; load_at = cyc;
        total++;
        if ({alu_num1, alu_num2, alu_out_sel} !== {8'h02, 8'h04, OP_ADD}) begin
          bad++; $display("FAIL single_load_bus got=%h", {alu_num1, alu_num2, alu_out_sel});
        end
      end
      if (res_valid && rise_at < 0) rise_at = cyc;
      if (res_valid && res_ready) begin
        got++;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL single_sb_empty got=%h", res_data);
        end else begin
          e = sb.pop_front();
          if (res_data !== e.d || res_op !== e.op) begin
            bad++; $display("FAIL single_res got=%h/%b exp=%h/%b",
                            res_data, res_op, e.d, e.op);
          end
        end
      end
    end
    @(posedge clk); #1;
    total++;
    if (got != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", got); end
    total++;
    if (loads != 1 || load_at != n0 + 1) begin
      bad++; $display("FAIL single_load got=%0d@%0d exp=1@%0d", loads, load_at, n0 + 1);
    end
    total++;
    if (rise_at != n0 + 2 + LAT) begin
      bad++; $display("FAIL single_latency got=%0d exp=%0d", rise_at, n0 + 2 + LAT);
    end
  endtask

  task automatic test_fill();
    bit         ok;
    int         acc, got, fails;
    logic [6:0] op;
    exp_t       e;
    res_ready = 1'b0;
    fails = 0;
    for (int i = 0; i < 5; i++) begin
      op = 7'b1000000 >> i;
      push0(8'h57, 8'h1A, op, ok);
      if (!ok) fails++;
    end
    total++;
    if (fails != 0) begin bad++; $display("FAIL fill_push got=%0d exp=0", fails); end
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", cmd_ready); end
    repeat (10) @(posedge clk);
    #1;
    total++;
    if ({cmd_ready, res_valid, busy} !== 3'b011) begin
      bad++; $display("FAIL fill_stall got=%b exp=011", {cmd_ready, res_valid, busy});
    end
    cmd_num1 = 8'h57; cmd_num2 = 8'h1A; cmd_op = 7'b0000010; cmd_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (cmd_ready) acc++;
    end
    @(posedge clk); #1;
    total++;
    if (acc != 0) begin bad++; $display("FAIL fill_refuse got=%0d exp=0", acc); end
    got = 0;
    fork
      begin
        push0(8'h57, 8'h1A, 7'b0000010, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL fill_sixth got=0 exp=1"); end
      end
      begin
        res_ready = 1'b1;
        for (int k = 0; k < 200 && got < 6; k++) begin
          @(negedge clk);
          if (res_valid && res_ready) begin
            got++;
            total++;
            if (sb.size() == 0) begin
              bad++; $display("FAIL fill_sb_empty got=%h", res_data);
            end else begin
              e = sb.pop_front();
              if (res_data !== e.d || res_op !== e.op) begin
                bad++; $display("FAIL fill_res%0d got=%h/%b exp=%h/%b",
                                got, res_data, res_op, e.d, e.op);
              end
            end
          end
        end
      end
    join
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (got != 6 || busy !== 1'b0) begin
      bad++; $display("FAIL fill_drain got=%0d/%b exp=6/0", got, busy);
    end
  endtask

  task automatic test_illegal();
    bit   ok1, ok2;
    int   errs, loads, got;
    exp_t e;
    res_ready = 1'b1;
    push0(8'h33, 8'h11, 7'b0000011, ok1);
    push0(8'h33, 8'h11, OP_SUB, ok2);
    total++;
    if (!(ok1 && ok2)) begin bad++; $display("FAIL illegal_push got=%b%b exp=11", ok1, ok2); end
    errs = 0; loads = 0; got = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (err_op) errs++;
      if (alu_in_sel == 3'b010) loads++;
      if (res_valid && res_ready) begin
        got++;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL illegal_sb_empty got=%h", res_data);
        end else begin
          e = sb.pop_front();
          if (res_data !== e.d || res_op !== e.op) begin
            bad++; $display("FAIL illegal_res got=%h/%b exp=%h/%b",
                            res_data, res_op, e.d, e.op);
          end
        end
      end
    end
    @(posedge clk); #1;
    total++;
    if (errs != (ERRCHK ? 1 : 0)) begin
      bad++; $display("FAIL illegal_err got=%0d exp=%0d", errs, ERRCHK ? 1 : 0);
    end
    total++;
    if (loads != (ERRCHK ? 1 : 2)) begin
      bad++; $display("FAIL illegal_loads got=%0d exp=%0d", loads, ERRCHK ? 1 : 2);
    end
    total++;
    if (got != (ERRCHK ? 1 : 2)) begin
      bad++; $display("FAIL illegal_results got=%0d exp=%0d", got, ERRCHK ? 1 : 2);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int fails, seen;
    res_ready = 1'b0;
    fails = 0;
    push0(8'h10, 8'h20, OP_AND, ok); if (!ok) fails++;
    push0(8'h30, 8'h40, OP_OR, ok);  if (!ok) fails++;
    push0(8'h50, 8'h60, OP_XOR, ok); if (!ok) fails++;
    @(negedge clk);
    total++;
    if (fails != 0 || alu_in_sel !== 3'b100 || alu_out_sel !== OP_AND ||
        res_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL midwait_state got=%0d/%b/%b/%b/%b",
                      fails, alu_in_sel, alu_out_sel, res_valid, busy);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({cmd_ready, alu_on, res_valid, err_op, busy} !== 5'b0 ||
        alu_in_sel !== 3'b001) begin
      bad++; $display("FAIL midwait_reset got=%b/%b exp=00000/001",
                      {cmd_ready, alu_on, res_valid, err_op, busy}, alu_in_sel);
    end
    total++;
    if ({alu_num1, alu_num2, alu_out_sel, res_data, res_op} !== 38'h0) begin
      bad++; $display("FAIL midwait_regs got=%h exp=0",
                      {alu_num1, alu_num2, alu_out_sel, res_data, res_op});
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    res_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (res_valid || busy) seen++;
    end
    @(posedge clk); #1;
    total++;
    if (seen != 0 || alu_on !== 1'b1) begin
      bad++; $display("FAIL midwait_after got=%0d/%b exp=0/1", seen, alu_on);
    end
  endtask

  task automatic test_stream();
    bit         ok;
    int         fails, got;
    logic [6:0] op;
    exp_t       e;
    fails = 0;
    got = 0;
    res1_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          op = 7'd1 << (i % 7);
          push1(8'(i * 17 + 3), 8'(i * 5 + 1), op, ok);
          if (!ok) fails++;
        end
      end
      begin
        for (int k = 0; k < 300 && got < 10; k++) begin
          @(negedge clk);
          if (res1_valid && res1_ready) begin
            got++;
            total++;
            if (q1.size() == 0) begin
              bad++; $display("FAIL stream_sb_empty got=%h", res1_data);
            end else begin
              e = q1.pop_front();
              if (res1_data !== e.d || res1_op !== e.op) begin
                bad++; $display("FAIL stream_res%0d got=%h/%b exp=%h/%b",
                                got, res1_data, res1_op, e.d, e.op);
              end
            end
          end
        end
      end
    join
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (fails != 0 || got != 10) begin
      bad++; $display("FAIL stream_count got=%0d/%0d exp=0/10", fails, got);
    end
    total++;
    if (busy1 !== 1'b0 || c1_ready !== 1'b1 || err1_op !== 1'b0) begin
      bad++; $display("FAIL stream_idle got=%b%b%b exp=010", busy1, c1_ready, err1_op);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_illegal();
    test_reset_mid();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-issue front end placed directly upstream of the 8-bit ALU `main`. Buffers operand/opcode commands in a small FIFO and sequences each one into the ALU: a load cycle, a fixed-latency wait, then result capture. Returns the ALU output on a valid/ready result port. Lets producers stream operations without knowing the ALU's `in_sel` protocol or its latency.

## Interface
Parameters:
- `DEPTH`, 4 — command FIFO entries; power of two, minimum 2.
- `ALU_LAT`, 2 — cycles from the ALU load cycle until `alu_out` is valid; minimum 1.

Ports:
- `clk`  in  1  — the single clock; all logic on rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `cmd_valid`  in  1  — command present.
- `cmd_ready`  out  1  — FIFO not full.
- `cmd_num1`, `cmd_num2`  in  8  — operands.
- `cmd_op`  in  7  — one-hot operation select, same encoding as ALU `out_sel`.
- `alu_on`  out  1  — ALU enable.
- `alu_in_sel`  out  3  — ALU input control: 100 persist, 010 load, 001 reset.
- `alu_num1`, `alu_num2`  out  8  — operands to the ALU.
- `alu_out_sel`  out  7  — operation to the ALU.
- `alu_out`  in  8  — ALU result.
- `res_valid`  out  1  — result held.
- `res_ready`  in  1  — consumer accepts the result.
- `res_data`  out  8  — captured result.
- `res_op`  out  7  — opcode that produced `res_data`.
- `err_op`  out  1  — one-cycle pulse when an illegal command is dropped.
- `busy`  out  1  — FSM not in IDLE, or FIFO not empty.

## Operation
- **Push:** a command is pushed when `cmd_valid && cmd_ready`. `cmd_ready = !full`.
- **Push and pop together:** a push and a pop in the same cycle leave the count unchanged. When the FIFO is full there is no push.
- **FSM states:** IDLE, LOAD, WAIT, DONE.
- **IDLE:**
  - `alu_in_sel = 100`.
  - If the FIFO is non-empty, pop the head.
  - A legal head goes to LOAD.
  - An illegal head is discarded, `err_op` pulses, and the FSM stays in IDLE.
- **LOAD** (1 cycle): `alu_in_sel = 010`. `alu_num1`, `alu_num2` and `alu_out_sel` are driven from the popped entry. Load the wait counter with `ALU_LAT-1`.
- **WAIT** (`ALU_LAT` cycles):
  - `alu_in_sel = 100`.
  - Operands and op stay stable.
  - When the counter reaches 0, capture `alu_out` into `res_data` and the op into `res_op`, set `res_valid`, and go to DONE.
- **DONE:** hold `res_valid`, `res_data` and `res_op` stable. When `res_ready` is high, clear `res_valid` and return to IDLE.
- **Registered outputs:** all ALU-side outputs are registered. They hold their last values in IDLE and DONE, except `alu_in_sel`.
- **`alu_on`:** 0 in reset; 1 from the first clock edge after `rst` deasserts.
- **Reset mid-operation:** FIFO emptied, FSM forced to IDLE, any in-flight result discarded, no `err_op`.
- **Width rules:**
  - FIFO pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - Count is `$clog2(DEPTH)+1` bits.
  - No arithmetic on data.

## Timing
- **Reset values:**
  - `cmd_ready` 0 while `rst` is low, 1 after.
  - `alu_on` 0; `alu_in_sel` 001.
  - `alu_num1`, `alu_num2`, `alu_out_sel` 0.
  - `res_valid` 0; `res_data` 0; `res_op` 0.
  - `err_op` 0; `busy` 0.
- **Latency:** command accepted at edge N, into an empty FIFO with the FSM in IDLE:
  - pop at N+1;
  - LOAD cycle N+2;
  - WAIT N+3..N+2+`ALU_LAT`;
  - `res_valid` high from N+3+`ALU_LAT` (N+5 at the default).
- **Throughput:** at best one command per `ALU_LAT+3` cycles. A stalled `res_ready` stalls issue; the FIFO continues to accept until full.
- **`err_op`:** high for exactly the cycle after the pop that dropped the command. Consecutive illegal entries give consecutive pulses.

## Configuration
- **`ALU_ISSUE_ERRCHK_EN` defined:** `cmd_op` is checked for exactly one set bit; zero or multiple bits make the command illegal, handled as above.
- **`ALU_ISSUE_ERRCHK_EN` undefined:** every command is issued unchanged, including non-one-hot ops, and `err_op` is tied to 0.

## Structure
- **Package `alu_pkg`:**
  - `OP_*` one-hot opcode constants (7 bits).
  - `INSEL_PERSIST`, `INSEL_LOAD`, `INSEL_RESET` constants.
  - FSM state enum (2 bits).
  - Packed command struct {num1, num2, op}.
- **Sub-module `alu_cmd_fifo`:** parameterised synchronous FIFO with push, pop, full, empty and head output. The FSM stays in `alu_cmd_issuer`.

## Test plan
- **Single command:** after reset, push num1=0x02, num2=0x04, op=1000000 at edge N → one LOAD cycle with `alu_in_sel=010` at N+2. `res_valid` rises at N+5 with `res_data` equal to the bench ALU model output and `res_op=1000000`.
- **Fill and backpressure:** hold `res_ready=0` and push 6 commands (num1=0x57, num2=0x1A, ops 1000000…0000010) → `cmd_ready` drops once the FIFO holds 4. The FIFO holds 4 entries with a 5th in flight in DONE, and the 6th push is refused until a pop. Results arrive in order after `res_ready=1`.
- **Illegal op** (macro defined): push op=0000011, then a legal op=0100000 → one `err_op` pulse, no LOAD for the illegal entry, legal result delivered. With the macro undefined, the same stimulus issues both and `err_op` stays 0.
- **Reset mid-WAIT:** assert `rst` low during WAIT with 2 entries queued → all outputs take their reset values immediately. After release, `busy=0` and no `res_valid` appears.
- **Simultaneous push/pop and wrap:** stream 10 commands back-to-back with `res_ready=1` and `ALU_LAT=1` → pointers wrap, count is never corrupted, and all 10 results match the model in order.
